// File: rtl/mem_arbiter.sv
// Arbitrates a single RAM port between an instruction fetch and a data requester.
// Data wins by default; a pending fetch is forced through after MAX_DSTREAK data grants.
module mem_arbiter #(
  parameter int unsigned MAX_DSTREAK = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iren,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dren,
  input  logic        dwen,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramren,
  output logic        ramwen,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic [2:0]  dstreak
);

  typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} state_t;
  typedef enum logic [1:0] {RAM_FREE, RAM_BUSY, RAM_ACCESS, RAM_ERROR} ram_state_t;

  localparam logic [2:0] STREAK_MAX = 3'(MAX_DSTREAK);

  state_t     state;
  state_t     cur;
  logic [2:0] streak;
  logic       d_req;
  logic       ram_done;

  assign d_req    = dren | dwen;
  assign ram_done = (ram_state_t'(ramstate) == RAM_ACCESS);

  // Reset masks the grant combinationally so an interrupted access never completes.
  always_comb begin
    cur = state;
    if (RST) cur = IDLE;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      streak <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_req && !(iren && streak == STREAK_MAX)) begin
            state <= DGRANT;
            if (!iren)
              streak <= '0;
            else if (streak < STREAK_MAX)
              streak <= streak + 3'd1;
          end else if (iren) begin
            state  <= IGRANT;
            streak <= '0;
          end
        end
        IGRANT:  if (!iren || ram_done) state <= IDLE;
        DGRANT:  if (!d_req || ram_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ramren   = 1'b0;
    ramwen   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    case (cur)
      IGRANT: begin
        ramren  = iren;
        ramaddr = iaddr;
        iwait   = !(iren && ram_done);
      end
      DGRANT: begin
        ramwen   = dwen;
        ramren   = dren & ~dwen;
        ramaddr  = daddr;
        ramstore = dstore;
        dwait    = !(d_req && ram_done);
      end
      default: ;
    endcase
  end

  assign iload   = ramload;
  assign dload   = ramload;
  assign dstreak = streak;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_DSTREAK, default 4: consecutive data grants allowed while iren is pending before instruction is forced.
REQ-002 SHALL have ports: CLK in 1 clock; RST in 1 reset, synchronous and active-high.
REQ-003 SHALL have ports: iren in 1 instruction read request; iaddr in 32 instruction address; iload out 32 instruction data; iwait out 1 instruction stall (0 = done this cycle).
REQ-004 SHALL have ports: dren in 1 data read request; dwen in 1 data write request; daddr in 32 data address; dstore in 32 write data; dload out 32 read data; dwait out 1 data stall (0 = done this cycle).
REQ-005 SHALL have ports: ramren out 1; ramwen out 1; ramaddr out 32; ramstore out 32; ramload in 32; ramstate in 2 (0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR).
REQ-006 SHALL have output dstreak out 3 current consecutive-data-grant count (status).

Function
REQ-007 SHALL implement a registered FSM with states IDLE, IGRANT, DGRANT; all state changes occur on CLK rising edge.
REQ-008 SHALL, in IDLE, drive ramren=0, ramwen=0, ramaddr=0, ramstore=0, iwait=1, dwait=1.
REQ-009 SHALL, in IDLE with any request, arbitrate: data (dren|dwen) wins over iren unless iren=1 and dstreak==MAX_DSTREAK, in which case IGRANT.
REQ-010 SHALL, in IDLE with no request, remain IDLE.
REQ-011 SHALL, in IGRANT, combinationally drive ramren=iren, ramwen=0, ramaddr=iaddr, ramstore=0.
REQ-012 SHALL, in DGRANT, combinationally drive ramwen=dwen, ramren=dren&~dwen, ramaddr=daddr, ramstore=dstore; dwen has precedence when both dren and dwen are 1.
REQ-013 SHALL assert iwait=0 only in IGRANT when ramstate==ACCESS; dwait=0 only in DGRANT when ramstate==ACCESS; otherwise both 1.
REQ-014 SHALL pass iload=ramload and dload=ramload unconditionally; values are valid only in the cycle the matching wait is 0.
REQ-015 SHALL return to IDLE the cycle after completion (ramstate==ACCESS in a grant state); minimum latency request-in-IDLE to wait=0 is 1 cycle, and back-to-back transactions are separated by one IDLE cycle.
REQ-016 SHALL treat ramstate BUSY, FREE and ERROR in a grant state as not done: hold grant, keep wait=1.
REQ-017 SHALL abort a grant if the granted requester drops its request (iren=0 in IGRANT; dren=dwen=0 in DGRANT): return to IDLE next cycle, no wait pulse, dstreak unchanged.
REQ-018 SHALL update dstreak on each IDLE arbitration decision: DGRANT with iren=1 -> dstreak+1 (saturate at MAX_DSTREAK); DGRANT with iren=0 -> 0; IGRANT -> 0.
REQ-019 SHALL never assert ramren and ramwen together, and never assert iwait=0 and dwait=0 together.
REQ-020 SHALL ignore changes of the non-granted requester's inputs while a grant is held.

Reset
REQ-021 SHALL, when RST=1 at a CLK edge, force state IDLE and dstreak=0 regardless of current state, including mid-transaction.
REQ-022 SHALL, during and one cycle after reset, present IDLE outputs (REQ-008); an interrupted transaction is not completed and must be re-requested.

Verification
REQ-023 Single I read: iren=1, iaddr=0x40, ramstate=ACCESS, ramload=0x8C010004 -> next cycle ramren=1, ramaddr=0x40, iwait=0, iload=0x8C010004; following cycle IDLE.
REQ-024 Simultaneous: iren=1, dwen=1, daddr=0x100, dstore=0xDEADBEEF -> DGRANT first (ramwen=1, ramstore=0xDEADBEEF, dwait=0), then IGRANT after one IDLE cycle.
REQ-025 Starvation: iren=1 held, data requests continuous, MAX_DSTREAK=4 -> four DGRANT completions, dstreak reaches 4, fifth grant is IGRANT, dstreak=0.
REQ-026 Latency: ramstate=BUSY for 3 cycles then ACCESS in DGRANT with dren=1 -> dwait=1 for 3 cycles, dwait=0 on 4th, ramren held 1 throughout.
REQ-027 Abort/reset: DGRANT with ramstate=BUSY, drop dren -> IDLE next cycle, dwait never 0; repeat with RST=1 instead -> IDLE, dstreak=0, ramren=ramwen=0.
REQ-028 Both dren=1 and dwen=1 in DGRANT -> ramwen=1, ramren=0; assertions for REQ-019 checked every cycle in all scenarios.
